// File: rtl/nn_result_streamer_pkg.sv
// Shared constants, state encodings and helpers for the result streamer.
package nn_result_streamer_pkg;

  localparam int D_LEN          = 16;
  localparam int O_NUM          = 4;
  localparam int OFS_WIDTH      = 8;
  localparam int DA_AWIDTH      = 8;
  localparam int BYTES_PER_WORD = D_LEN / 8;
  localparam int BCNT_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [DA_AWIDTH-1:0] OPM_BASE = '0;
  localparam logic [7:0]           HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_SEND,
    ST_NEXT,
    ST_CKSUM,
    ST_DONE
  } state_t;

  typedef enum logic {
    HS_IDLE,
    HS_REQ
  } hs_state_t;

  function automatic logic [7:0] top_byte(input logic [D_LEN-1:0] w);
    return w[D_LEN-1 -: 8];
  endfunction

endpackage

// File: rtl/nn_result_streamer_if.sv
// Output-memory read port plus UART TX byte port seen by the result streamer.
interface nn_result_streamer_if;
  import nn_result_streamer_pkg::*;

  logic [DA_AWIDTH-1:0] opm_base;
  logic [OFS_WIDTH-1:0] opm_offset;
  logic [D_LEN-1:0]     opm_dout;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_ready;

  modport master (
    output opm_base, opm_offset, tx_data, tx_start,
    input  opm_dout, tx_ready
  );

  modport slave (
    input  opm_base, opm_offset, tx_data, tx_start,
    output opm_dout, tx_ready
  );

endinterface

// File: rtl/nn_result_streamer_tx_byte_handshake.sv
// One byte per 4-phase request/ack on a synchronized tx_ready; start rises 1 cycle after req meets
// synced ready, ack pulses the cycle synced ready drops, and req is ignored until ready is high again.
module nn_result_streamer_tx_byte_handshake
  import nn_result_streamer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_i,
  input  logic [7:0] byte_i,
  output logic       ack_o,
  output logic [7:0] tx_data_o,
  output logic       tx_start_o,
  input  logic       tx_ready_i
);

  hs_state_t  state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       start_q, start_d;
  logic       rdy_meta_q, rdy_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HS_IDLE;
      data_q     <= '0;
      start_q    <= 1'b0;
      rdy_meta_q <= 1'b0;
      rdy_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      start_q    <= start_d;
      rdy_meta_q <= tx_ready_i;
      rdy_sync_q <= rdy_meta_q;
    end
  end

  // data_q is only loaded while start is low, so the byte is frozen for the whole request phase
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    start_d = start_q;
    ack_o   = 1'b0;
    case (state_q)
      HS_IDLE: begin
        if (req_i && rdy_sync_q) begin
          data_d  = byte_i;
          start_d = 1'b1;
          state_d = HS_REQ;
        end
      end
      HS_REQ: begin
        if (!rdy_sync_q) begin
          start_d = 1'b0;
          ack_o   = 1'b1;
          state_d = HS_IDLE;
        end
      end
      default: state_d = HS_IDLE;
    endcase
  end

  assign tx_data_o  = data_q;
  assign tx_start_o = start_q;

endmodule

// File: rtl/nn_result_streamer.sv
// Streams A5, O_NUM output words MSB byte first, then an XOR checksum of the data bytes over UART.
// First tx_start 2 cycles after nn_finish; each byte waits on the transmitter's 4-phase handshake.
module nn_result_streamer
  import nn_result_streamer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 nn_finish,
  nn_result_streamer_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  state_t               state_q, state_d;
  logic [OFS_WIDTH-1:0] index_q, index_d;
  logic [OFS_WIDTH-1:0] offset_q, offset_d;
  logic [D_LEN-1:0]     shift_q, shift_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic [7:0]           cksum_q, cksum_d;
  logic                 busy_q, busy_d;

  logic       hs_req;
  logic [7:0] hs_byte;
  logic       hs_ack;

  nn_result_streamer_tx_byte_handshake u_hs (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (hs_req),
    .byte_i     (hs_byte),
    .ack_o      (hs_ack),
    .tx_data_o  (bus.tx_data),
    .tx_start_o (bus.tx_start),
    .tx_ready_i (bus.tx_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      index_q  <= '0;
      offset_q <= '0;
      shift_q  <= '0;
      bcnt_q   <= '0;
      cksum_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      offset_q <= offset_d;
      shift_q  <= shift_d;
      bcnt_q   <= bcnt_d;
      cksum_q  <= cksum_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    offset_d = offset_q;
    shift_d  = shift_q;
    bcnt_d   = bcnt_q;
    cksum_d  = cksum_q;
    busy_d   = busy_q;
    hs_req   = 1'b0;
    hs_byte  = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (nn_finish) begin
          state_d = ST_HDR;
          busy_d  = 1'b1;
          index_d = '0;
          cksum_d = '0;
        end
      end
      ST_HDR: begin
        hs_req  = 1'b1;
        hs_byte = HDR_BYTE;
        if (hs_ack) state_d = ST_RD_ADDR;
      end
      ST_RD_ADDR: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        shift_d = bus.opm_dout;
        bcnt_d  = BCNT_W'(BYTES_PER_WORD - 1);
        state_d = ST_SEND;
      end
      ST_SEND: begin
        hs_req  = 1'b1;
        hs_byte = top_byte(shift_q);
        if (hs_ack) begin
          cksum_d = cksum_q ^ hs_byte;
          shift_d = shift_q << 8;
          if (bcnt_q == '0) begin
            state_d = ST_NEXT;
          end else begin
            bcnt_d = bcnt_q - 1'b1;
          end
        end
      end
      ST_NEXT: begin
        if (index_q == OFS_WIDTH'(O_NUM - 1)) begin
          state_d = ST_CKSUM;
        end else begin
          index_d = index_q + 1'b1;
          state_d = ST_RD_ADDR;
        end
      end
      ST_CKSUM: begin
        hs_req  = 1'b1;
        hs_byte = cksum_q;
        if (hs_ack) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Offset is registered on entry to RD_ADDR so the synchronous memory has a full cycle
    // with a stable address before RD_WAIT captures its output.
    if (state_d == ST_RD_ADDR) offset_d = index_d;
  end

  assign bus.opm_base   = OPM_BASE;
  assign bus.opm_offset = offset_q;
  assign busy           = busy_q;
  assign done           = (state_q == ST_DONE);
  assign overrun        = nn_finish && busy_q;

endmodule

// File: tb/tb_nn_result_streamer.sv
// Scoreboarded bench: frames predicted from memory contents, bytes checked as the DUT offers them.
module tb_nn_result_streamer;
  import nn_result_streamer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic nn_finish = 1'b0;
  logic busy, done, overrun;

  nn_result_streamer_if bus ();

  nn_result_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nn_finish (nn_finish),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  logic [D_LEN-1:0] mem [0:255];
  logic [D_LEN-1:0] dout_q = '0;
  logic rdy_m = 1'b1;
  logic force_low = 1'b0;

  always @(posedge clk) dout_q <= mem[bus.opm_offset];
  assign bus.opm_dout = dout_q;
  assign bus.tx_ready = rdy_m & ~force_low;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int frames_pending = 0;
  int n_falls = 0;
  int done_cnt = 0;
  int ack_dly = 0;
  int rel_dly = 0;
  logic prev_start = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0] exp_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Reference frame: header, every word's bytes high to low, XOR of those data bytes.
  task automatic push_expected();
    logic [7:0] b;
    logic [7:0] cs;
    cs = 8'h00;
    exp_q.push_back(HDR_BYTE);
    for (int w = 0; w < O_NUM; w++) begin
      for (int k = BYTES_PER_WORD - 1; k >= 0; k--) begin
        b = 8'(mem[w] >> (8 * k));
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
    exp_q.push_back(cs);
    frames_pending++;
  endtask

  task automatic start_frame(input bit randomize_mem);
    if (randomize_mem) begin
      for (int w = 0; w < O_NUM; w++) mem[w] = D_LEN'($urandom);
    end
    push_expected();
    nn_finish = 1'b1;
    cyc();
    nn_finish = 1'b0;
  endtask

  task automatic wait_done(input bit poke_in_done);
    int n;
    n = 0;
    while (!done && n < 20000) begin
      cyc();
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected a done pulse", n);
    end else begin
      chk("busy_in_done", 32'(busy), 32'd1);
      if (poke_in_done) begin
        nn_finish = 1'b1;
        #1;
        chk("overrun_in_done", 32'(overrun), 32'd1);
      end
      cyc();
      nn_finish = 1'b0;
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  // Transmitter: ack after ack_dly cycles, release ready rel_dly cycles after start drops.
  initial begin
    int n;
    forever begin
      @(negedge clk);
      if (rst_n && bus.tx_start) begin
        repeat (ack_dly) @(negedge clk);
        rdy_m = 1'b0;
        n = 0;
        while (bus.tx_start && n < 1000) begin
          @(negedge clk);
          n++;
        end
        if (bus.tx_start) begin
          checks++;
          errors++;
          $display("FAIL tx_start_release: got tx_start=1 after ack expected 0");
        end
        repeat (rel_dly) @(negedge clk);
        rdy_m = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start = 1'b0;
      prev_data  = '0;
    end else begin
      if (bus.tx_start && !prev_start) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL byte_unexpected: got 0x%0h expected no byte", bus.tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          chk("frame_byte", 32'(bus.tx_data), 32'(exp_b));
        end
      end else if (bus.tx_start && prev_start) begin
        chk("tx_data_stable", 32'(bus.tx_data), 32'(prev_data));
      end
      if (!bus.tx_start && prev_start) n_falls++;
      if (done) begin
        done_cnt++;
        checks++;
        if (frames_pending == 0 || exp_q.size() != 0) begin
          errors++;
          $display("FAIL done_unexpected: got pending=%0d bytes_left=%0d expected pending>0 bytes_left=0",
                   frames_pending, exp_q.size());
        end else begin
          frames_pending--;
        end
      end
      prev_start = bus.tx_start;
      prev_data  = bus.tx_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bad;
    int n;
    int d0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_offset", 32'(bus.opm_offset), 32'd0);
    chk("rst_base", 32'(bus.opm_base), 32'(OPM_BASE));
    rst_n = 1'b1;
    repeat (4) cyc();

    // Directed frame: A5 12 34 AB CD 00 00 00 00 40, plus trigger latency and DONE-cycle overrun
    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;
    mem[2] = 16'h0000;
    mem[3] = 16'h0000;
    ack_dly = 1;
    rel_dly = 1;
    start_frame(1'b0);
    chk("latency_cycle1", 32'(bus.tx_start), 32'd0);
    chk("busy_after_trigger", 32'(busy), 32'd1);
    cyc();
    chk("latency_cycle2", 32'(bus.tx_start), 32'd1);
    wait_done(1'b1);
    repeat (5) cyc();
    chk("no_restart_after_done_poke", 32'(busy), 32'd0);

    // Slow transmitter
    ack_dly = 37;
    rel_dly = 11;
    start_frame(1'b1);
    wait_done(1'b0);

    // Second trigger mid-frame
    ack_dly = 2;
    rel_dly = 1;
    d0 = done_cnt;
    start_frame(1'b1);
    repeat (10) cyc();
    nn_finish = 1'b1;
    #1;
    chk("overrun_pulse", 32'(overrun), 32'd1);
    cyc();
    nn_finish = 1'b0;
    #1;
    chk("overrun_single", 32'(overrun), 32'd0);
    wait_done(1'b0);
    repeat (30) cyc();
    chk("overrun_one_done", 32'(done_cnt - d0), 32'd1);
    chk("overrun_no_second_frame", 32'(bus.tx_start), 32'd0);

    // Random frames and handshake timing
    for (int f = 0; f < 6; f++) begin
      ack_dly = $urandom_range(0, 4);
      rel_dly = $urandom_range(0, 4);
      start_frame(1'b1);
      wait_done(1'b0);
      repeat ($urandom_range(0, 5)) cyc();
    end

    // Reset after the third byte is acknowledged
    ack_dly = 1;
    rel_dly = 1;
    base = n_falls;
    start_frame(1'b1);
    n = 0;
    while (n_falls < base + 3 && n < 2000) begin
      cyc();
      n++;
    end
    chk("mid_reset_reached_byte3", 32'(n_falls - base >= 3), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_tx_start", 32'(bus.tx_start), 32'd0);
    chk("mid_reset_busy", 32'(busy), 32'd0);
    chk("mid_reset_base", 32'(bus.opm_base), 32'(OPM_BASE));
    exp_q.delete();
    frames_pending = 0;
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    start_frame(1'b1);
    wait_done(1'b0);

    // Trigger while the transmitter is not ready
    force_low = 1'b1;
    repeat (4) cyc();
    start_frame(1'b1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.tx_start !== 1'b0 || busy !== 1'b1) bad++;
      cyc();
    end
    chk("held_low_idle_cycles_bad", 32'(bad), 32'd0);
    force_low = 1'b0;
    n = 0;
    while (!bus.tx_start && n < 10) begin
      cyc();
      n++;
    end
    chk("hdr_within_3_after_ready", 32'(n >= 1 && n <= 3), 32'd1);
    wait_done(1'b0);

    repeat (10) cyc();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("frames_all_done", 32'(frames_pending), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_result_streamer.md
Name: nn_result_streamer

Overview:
- Sequences readout of the network output memory after inference and streams the results as a framed byte sequence through the shared UART transmitter.
- Triggered by the network finish strobe. Walks output-memory offsets, serializes each D_LEN-bit word MSB-byte-first, and appends an XOR checksum.
- Sits between the output memory read port and the UART TX byte interface. Replaces ad-hoc readout logic in the serial controller.

Parameters:
- D_LEN, 16, output word width in bits; must be a multiple of 8.
- O_NUM, 4, number of output words per frame (1..2^OFS_WIDTH).
- OFS_WIDTH, 8, width of the output-memory offset bus.
- DA_AWIDTH, 8, width of the output-memory base bus.
- OPM_BASE, 0, base address of the output layer block.
- HDR_BYTE, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- nn_finish  in  1  single-cycle pulse: network results valid
- opm_base  out  DA_AWIDTH  output-memory base address
- opm_offset  out  OFS_WIDTH  output-memory word offset
- opm_dout  in  D_LEN  output-memory read data, 1-cycle synchronous read latency
- tx_data  out  8  byte to transmit
- tx_start  out  1  transmit request, level, 4-phase handshake
- tx_ready  in  1  transmitter idle; sampled in clk domain
- busy  out  1  high from accepted trigger until done
- done  out  1  one-cycle pulse after the checksum byte is acknowledged
- overrun  out  1  one-cycle pulse when nn_finish arrives while busy

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values: all outputs 0, except opm_base = OPM_BASE. State = IDLE, word index = 0, checksum = 0.
- tx_ready synchronization: tx_ready is double-flop synchronized inside the block. The handshake uses only the synchronized version.
- TX handshake (4-phase):
  - Drive tx_data and raise tx_start only when the synced tx_ready = 1.
  - Hold tx_data and tx_start stable until the synced tx_ready = 0 (ack).
  - Then drop tx_start and wait for the synced tx_ready = 1 before the next byte.
  - tx_data must never change while tx_start = 1.
- States:
  - IDLE: on nn_finish go to HDR, busy <= 1, index <= 0, checksum <= 0.
  - HDR: send HDR_BYTE via the handshake; then RD_ADDR. The header is excluded from the checksum.
  - RD_ADDR: opm_offset <= index; then RD_WAIT (one cycle).
  - RD_WAIT: latch opm_dout into the shift register; byte counter <= D_LEN/8 - 1; then SEND.
  - SEND: send shift[D_LEN-1 -: 8]. On ack, checksum ^= byte and shift <<= 8.
    - Byte counter = 0: go to NEXT.
    - Otherwise decrement the byte counter and repeat SEND.
  - NEXT: if index = O_NUM-1 go to CKSUM; else index += 1 and go to RD_ADDR.
  - CKSUM: send the checksum byte; then DONE.
  - DONE: done = 1 for one cycle, busy <= 0; return to IDLE.
- Latency: from nn_finish to HDR tx_start is 2 cycles, provided tx_ready has been high for at least 2 cycles.
- Frame length: 2 + O_NUM*D_LEN/8 bytes.
- nn_finish while busy: ignored, overrun pulses the same cycle, the frame in progress is unaffected.
- nn_finish in the DONE cycle: counted as busy, so it is overrun.
- Index arithmetic: index never exceeds O_NUM-1, so there is no wrap. opm_offset holds its last value between frames.
- Reset mid-frame: immediate return to IDLE with tx_start = 0. The partial frame is abandoned and the receiver resyncs on HDR_BYTE.
- tx_ready low at trigger: the block waits in HDR indefinitely with tx_start = 0. There is no timeout.

Decomposition:
- Shared define header holds: D_LEN, OFS_WIDTH, DA_AWIDTH, O_NUM, HDR_BYTE, and the state encodings.
- Natural sub-module: tx_byte_handshake. It contains the tx_ready synchronizer and the 4-phase request/ack FSM. Interface: req/byte in, ack pulse out.
- Word index, shift register and checksum stay in the top FSM.

Test Plan:
- Basic frame: O_NUM=2, D_LEN=16, memory = {0x1234, 0xABCD}; pulse nn_finish; TX model acks each byte -> bytes A5 12 34 AB CD 40. done pulses once after the 0x40 ack and busy falls the same cycle.
- Handshake integrity: TX model delays ack 37 cycles and release 11 cycles -> tx_data is stable throughout every tx_start=1 interval and no byte is duplicated or skipped.
- Overrun: second nn_finish 10 cycles into the frame -> overrun pulses once, frame bytes unchanged, only one done.
- Read latency: memory returns new data exactly 1 cycle after opm_offset changes; offsets 0,1,2,3 with O_NUM=4 -> each word is captured from its own offset and the checksum matches the XOR of all 8 data bytes.
- Reset mid-frame: assert rst_n=0 after the 3rd byte ack -> tx_start=0, busy=0, opm_base=OPM_BASE immediately. After release, a new nn_finish yields a complete frame starting A5.
- tx_ready held low: nn_finish with tx_ready=0 for 100 cycles -> tx_start stays 0 and busy=1. After tx_ready rises, HDR is sent within 3 cycles.
